wishbone_rr_arbiter: RTL

- Shares one WISHBONE slave port among NUM_MASTERS masters using round-robin arbitration with per-cycle-grant locking.
- Sits between the CPU/DMA/debug masters and the MMIO slave decoder.
- Includes a watchdog that terminates a stalled transfer with an error strobe, so a hung slave cannot lock up the bus.

---
 rtl/wishbone_arb_pkg.sv | 30 +++
 rtl/rr_priority_pick.sv | 17 +
 rtl/wishbone_rr_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/wishbone_arb_pkg.sv
// Shared types and the round-robin pick function for WISHBONE bus arbiters.
package wishbone_arb_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned MAX_IDX_W   = 3;

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} arb_state_t;

  // One-hot pick of the first set req bit at or after ptr, wrapping within n.
  function automatic logic [MAX_MASTERS-1:0] rr_pick(
    input logic [MAX_MASTERS-1:0] req,
    input logic [MAX_IDX_W-1:0]   ptr,
    input int unsigned            n
  );
    logic [MAX_MASTERS-1:0] pick;
    logic                   found;
    logic [MAX_IDX_W-1:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < MAX_MASTERS; off++) begin
      idx = MAX_IDX_W'((32'(ptr) + off) % n);
      if (off < n && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: req + priority pointer -> one-hot winner.
module rr_priority_pick
  import wishbone_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick
);

  always_comb begin
    pick = NUM_REQ'(rr_pick(MAX_MASTERS'(req), MAX_IDX_W'(ptr), NUM_REQ));
  end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin WISHBONE arbiter: NUM_MASTERS masters share one slave port,
// grant held for a whole CYC, watchdog terminates stalled strobes with m_err.
module wishbone_rr_arbiter
  import wishbone_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc,
  input  logic [NUM_MASTERS-1:0]            m_stb,
  input  logic [NUM_MASTERS-1:0]            m_we,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic                              s_cyc,
  output logic                              s_stb,
  output logic                              s_we,
  input  logic                              s_ack,
  output logic [NUM_MASTERS-1:0]            grant
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t             state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       g_idx;
  logic [IDX_W-1:0]       ptr_next;
  logic [WD_W-1:0]        wd_cnt;
  logic [NUM_MASTERS-1:0] pick;
  logic                   owner_cyc;
  logic                   owner_stb;
  logic                   owner_we;
  logic [ADDR_WIDTH-1:0]  owner_addr;
  logic [DATA_WIDTH-1:0]  owner_dat;
  logic                   busy;
  logic                   stall;
  logic                   timeout;

  rr_priority_pick #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req  (m_cyc),
    .ptr  (ptr),
    .pick (pick)
  );

  // Select the current owner's signals (grant is one-hot or zero).
  always_comb begin
    g_idx      = '0;
    owner_cyc  = 1'b0;
    owner_stb  = 1'b0;
    owner_we   = 1'b0;
    owner_addr = '0;
    owner_dat  = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        g_idx      = IDX_W'(i);
        owner_cyc  = m_cyc[i];
        owner_stb  = m_stb[i];
        owner_we   = m_we[i];
        owner_addr = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        owner_dat  = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ptr_next = (g_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : g_idx + IDX_W'(1);
  assign busy     = (state == BUSY);
  assign stall    = busy && s_stb && !s_ack;
  assign timeout  = stall && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  // Slave port follows the owner only while BUSY; a dropped CYC is seen at once.
  assign s_cyc   = busy & owner_cyc;
  assign s_stb   = busy & owner_cyc & owner_stb;
  assign s_we    = busy & owner_we;
  assign s_addr  = busy ? owner_addr : '0;
  assign s_dat_i = busy ? owner_dat : '0;
  assign m_dat_o = s_dat_o;
  assign m_ack   = grant & {NUM_MASTERS{busy & s_ack & owner_stb}};
  assign m_err   = grant & {NUM_MASTERS{timeout}};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      grant  <= '0;
      ptr    <= '0;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (|m_cyc) begin
            grant <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_cyc) begin
            state  <= IDLE;
            grant  <= '0;
            ptr    <= ptr_next;
            wd_cnt <= '0;
          end else if (timeout) begin
            state  <= FLUSH;
            wd_cnt <= '0;
          end else if (stall) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end else begin
            wd_cnt <= '0;
          end
        end
        FLUSH: begin
          wd_cnt <= '0;
          if (!owner_cyc) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= ptr_next;
          end
        end
        default: begin
          state  <= IDLE;
          grant  <= '0;
          wd_cnt <= '0;
        end
      endcase
    end
  end

endmodule
